// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: access-size encodings, lane count and alignment/lane helpers for ram_arb.
package ram_arb_pkg;
  localparam int LANES = 4;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) | (size == SIZE_H && off[0]) | (size == SIZE_W && off != 2'b00);
  endfunction
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_B ? 4'b0001 << off : size == SIZE_H ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/ram_arb_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; prio points at the master that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;
  always_comb gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
endmodule

// File: rtl/ram_arb.sv
// ram_arb: two-master round-robin access controller for the byte-lane data RAM,
// with lane steering, alignment checking and a one-deep read-return register.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [1:0]            m0_size_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [1:0]            m1_size_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [LANES-1:0]      ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);
  logic [1:0]            gnt, size, rd_off, rd_size;
  logic                  sel, any, we, err, rd_pend, rd_mst;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, shifted, rdata;
  // requests are masked while in reset so every output reads zero
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1_req_i, m0_req_i} & {2{rst_n}}),
    .gnt  (gnt)
  );
  always_comb begin
    sel           = gnt[1];
    any           = |gnt;
    we            = sel ? m1_we_i : m0_we_i;
    size          = sel ? m1_size_i : m0_size_i;
    addr          = sel ? m1_addr_i : m0_addr_i;
    wdata         = sel ? m1_wdata_i : m0_wdata_i;
    err           = misaligned(size, addr[1:0]);
    m0_ack_o      = gnt[0];
    m1_ack_o      = gnt[1];
    m0_err_o      = gnt[0] & err;
    m1_err_o      = gnt[1] & err;
    ram_wr_en_o   = (any && we && !err) ? lane_mask(size, addr[1:0]) : '0;
    ram_wr_addr_o = rst_n ? addr : '0;
    ram_rd_addr_o = rst_n ? addr : '0;
    ram_wr_data_o = !rst_n ? '0 : size == SIZE_B ? {LANES{wdata[7:0]}} :
                    size == SIZE_H ? {2{wdata[15:0]}} : wdata;
    shifted       = ram_rd_data_i >> {rd_off, 3'b000};
    rdata         = rd_size == SIZE_B ? DATA_WIDTH'(shifted[7:0]) :
                    rd_size == SIZE_H ? DATA_WIDTH'(shifted[15:0]) : shifted;
    m0_rvalid_o   = rd_pend & ~rd_mst;
    m1_rvalid_o   = rd_pend & rd_mst;
    m0_rdata_o    = m0_rvalid_o ? rdata : '0;
    m1_rdata_o    = m1_rvalid_o ? rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_mst  <= 1'b0;
      rd_off  <= 2'b00;
      rd_size <= 2'b00;
    end else begin
      rd_pend <= any & ~we & ~err;
      rd_mst  <= sel;
      rd_off  <= addr[1:0];
      rd_size <= size;
    end
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: table-driven vectors plus directed contention/reset sequences; read data checked via a scoreboard queue.
module tb_ram_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m0_rvalid, m1_ack, m1_err, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [31:0] mem [64];
  int          chk = 0, pass = 0, cyc = 0;

  typedef struct {bit m; logic [31:0] d; int due;} exp_t;
  exp_t sb[$];

  typedef struct {
    bit m; bit we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;
    bit err; logic [3:0] wen; logic [31:0] wd; logic [31:0] rd;
  } vec_t;
  vec_t vecs[19];

  ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_size_i(m0_size), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_size_i(m1_size), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_wr_en_o(wr_en), .ram_wr_addr_o(wr_addr), .ram_wr_data_o(wr_data),
    .ram_rd_addr_o(rd_addr), .ram_rd_data_i(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous byte-lane RAM
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (wr_en[l]) mem[wr_addr[7:2]][l*8 +: 8] <= wr_data[l*8 +: 8];
    rd_data <= mem[rd_addr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid_m0", 32'(m0_rvalid), 32'(!e.m));
      check("rvalid_m1", 32'(m1_rvalid), 32'(e.m));
      check("rdata", e.m ? m1_rdata : m0_rdata, e.d);
    end else check("no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
  end

  task automatic idle();
    m0_req = 0; m1_req = 0;
  endtask

  task automatic drive(input bit m, input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    idle();
    if (m) begin m1_req = 1; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; end
    else   begin m0_req = 1; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; end
  endtask

  task automatic push(input bit m, input logic [31:0] d);
    exp_t e;
    e.m = m; e.d = d; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_acks"}, {28'b0, m1_ack, m1_err, m0_ack, m0_err}, 32'h0);
    check({tag, "_rdata"}, m0_rdata | m1_rdata, 32'h0);
    check({tag, "_wr_en"}, {28'b0, wr_en}, 32'h0);
    check({tag, "_addr"}, wr_addr | rd_addr, 32'h0);
    check({tag, "_wr_data"}, wr_data, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 0, 2'd2, 32'h10, 32'h0,        0, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1, 1, 2'd0, 32'h13, 32'h000000AB, 0, 4'h8, 32'hABABABAB, 32'h0};
    vecs[3]  = '{1, 0, 2'd0, 32'h13, 32'h0,        0, 4'h0, 32'h0,        32'h000000AB};
    vecs[4]  = '{1, 1, 2'd0, 32'h12, 32'h000000BE, 0, 4'h4, 32'hBEBEBEBE, 32'h0};
    vecs[5]  = '{1, 0, 2'd1, 32'h12, 32'h0,        0, 4'h0, 32'h0,        32'h0000ABBE};
    vecs[6]  = '{0, 0, 2'd2, 32'h02, 32'h0,        1, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{0, 1, 2'd1, 32'h05, 32'h00001234, 1, 4'h0, 32'h0,        32'h0};
    vecs[8]  = '{0, 1, 2'd3, 32'h08, 32'h55555555, 1, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{0, 1, 2'd2, 32'h04, 32'h0,        0, 4'hF, 32'h0,        32'h0};
    vecs[10] = '{0, 1, 2'd1, 32'h06, 32'h0000CAFE, 0, 4'hC, 32'hCAFECAFE, 32'h0};
    vecs[11] = '{0, 1, 2'd2, 32'h00, 32'h11223344, 0, 4'hF, 32'h11223344, 32'h0};
    vecs[12] = '{0, 0, 2'd2, 32'h00, 32'h0,        0, 4'h0, 32'h0,        32'h11223344};
    vecs[13] = '{0, 0, 2'd2, 32'h04, 32'h0,        0, 4'h0, 32'h0,        32'hCAFE0000};
    vecs[14] = '{1, 0, 2'd1, 32'h06, 32'h0,        0, 4'h0, 32'h0,        32'h0000CAFE};
    vecs[15] = '{0, 0, 2'd0, 32'h11, 32'h0,        0, 4'h0, 32'h0,        32'h000000BE};
    vecs[16] = '{0, 1, 2'd0, 32'h21, 32'h0000005A, 0, 4'h2, 32'h5A5A5A5A, 32'h0};
    vecs[17] = '{0, 0, 2'd0, 32'h21, 32'h0,        0, 4'h0, 32'h0,        32'h0000005A};
    vecs[18] = '{1, 0, 2'd2, 32'h10, 32'h0,        0, 4'h0, 32'h0,        32'hABBEBEEF};

    // reset with a live request: every output must stay zero
    rst_n = 0;
    drive(0, 1, 2'd2, 32'h10, 32'hFFFFFFFF);
    m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1; idle();

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].m, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].we && !vecs[i].err) push(vecs[i].m, vecs[i].rd);
      @(negedge clk);
      check($sformatf("v%0d_ack", i), {30'b0, m1_ack, m0_ack}, vecs[i].m ? 32'h2 : 32'h1);
      check($sformatf("v%0d_err", i), 32'(m0_err | m1_err), 32'(vecs[i].err));
      check($sformatf("v%0d_wr_en", i), {28'b0, wr_en}, {28'b0, vecs[i].wen});
      if (vecs[i].wen != 0) begin
        check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wd);
        check($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].addr);
      end
      if (!vecs[i].we && !vecs[i].err) check($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].addr);
    end

    // contention: both masters read every cycle, grants must alternate from m0
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_size = 2'd2; m0_addr = 32'h00;
    m1_req = 1; m1_we = 0; m1_size = 2'd2; m1_addr = 32'h04;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      push(k[0], k[0] ? 32'hCAFE0000 : 32'h11223344);
      @(negedge clk);
      check($sformatf("cont%0d_ack", k), {30'b0, m1_ack, m0_ack}, k[0] ? 32'h2 : 32'h1);
      check($sformatf("cont%0d_rd_addr", k), rd_addr, k[0] ? 32'h04 : 32'h00);
    end

    // m0 read leaves prio at m1; reset lands in the rvalid cycle
    @(posedge clk); #1;
    drive(0, 0, 2'd2, 32'h10, 32'h0);
    @(negedge clk);
    check("rst_rd_ack", {30'b0, m1_ack, m0_ack}, 32'h1);
    @(posedge clk); #1 idle(); rst_n = 0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_size = 2'd2; m0_addr = 32'h00;
    m1_req = 1; m1_we = 0; m1_size = 2'd2; m1_addr = 32'h04;
    push(0, 32'h11223344);
    @(negedge clk);
    check("post_rst_prio", {30'b0, m1_ack, m0_ack}, 32'h1);
    @(posedge clk); #1 m0_req = 0;
    push(1, 32'hCAFE0000);
    @(negedge clk);
    check("post_rst_m1", {30'b0, m1_ack, m0_ack}, 32'h2);
    @(posedge clk); #1 idle();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
# ram_arb

Two-master arbiter and access controller for the byte-lane data RAM. Arbitrates between the core load/store port (m0) and the debug/DMA port (m1) using round-robin priority. For byte, half-word and word accesses it generates the RAM's per-lane write enables, replicates write data across lanes and extracts aligned read data. It tracks the RAM's one-cycle read latency so that one access can be granted per cycle without bubbles.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: master address width (matches `RV32_ADDR_WIDTH`).
- `DATA_WIDTH`, default 32: data width; 4 byte lanes.

Ports:
- `clk` in 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `mN_req_i` in 1, N=0,1: request valid, held until ack.
- `mN_we_i` in 1: 1 = write, 0 = read.
- `mN_size_i` in 2: access size; 00 byte, 01 half, 10 word; 11 is illegal and treated as an error.
- `mN_addr_i` in ADDR_WIDTH: byte address.
- `mN_wdata_i` in DATA_WIDTH: write data, right-justified.
- `mN_ack_o` out 1: request accepted this cycle.
- `mN_err_o` out 1: misaligned or illegal access; asserted with ack; no RAM access is made.
- `mN_rvalid_o` out 1: read data valid, one cycle after ack.
- `mN_rdata_o` out DATA_WIDTH: read data, right-justified and zero-extended.
- `ram_wr_en_o` out 4: per-lane write enable.
- `ram_wr_addr_o` out ADDR_WIDTH: write address.
- `ram_wr_data_o` out DATA_WIDTH: lane-replicated write data.
- `ram_rd_addr_o` out ADDR_WIDTH: read address.
- `ram_rd_data_i` in DATA_WIDTH: synchronous read data, valid one cycle after the address.

## Operation
- **Grant.** Grant is combinational from `req` and the priority pointer `prio`.
  - If only one master requests, it is granted.
  - If both request, the master indicated by `prio` is granted.
  - `prio` flips to the other master after every grant, including error grants.
  - `prio` resets to m0.
- **Alignment check.**
  - Half access with `addr[0]`=1: error.
  - Word access with `addr[1:0]`≠0: error.
  - Size 11: error.
  - On error: ack and err pulse together for one cycle; `ram_wr_en_o`=0; no rvalid follows.
- **Write.**
  - Byte: `ram_wr_en_o` = 4'b0001 << off, data replicated as {4{wdata[7:0]}}.
  - Half: `ram_wr_en_o` = 4'b0011 << off, data replicated as {2{wdata[15:0]}}.
  - Word: `ram_wr_en_o` = 4'b1111, data = wdata.
  - `off` = `addr[1:0]`. The write completes in the ack cycle.
- **Read.**
  - `ram_rd_addr_o` = granted address in the ack cycle.
  - Registers `rd_pend`, `rd_mst`, `rd_off` and `rd_size` are loaded in the ack cycle.
  - Next cycle: `rvalid` pulses to `rd_mst`. `rdata` = (`ram_rd_data_i` >> 8·`rd_off`), masked to 8, 16 or 32 bits according to `rd_size`.
- **Pipelining.** Read-data return (registered state) and a new grant may occur in the same cycle. Sustained throughput is one access per cycle.
- **Read-after-write.** A write in cycle N followed by a read of the same address in cycle N+1 returns the new data. The arbiter never issues a read and a write in the same cycle.
- **Idle outputs.** When no grant is active: `ram_wr_en_o`=0, and the address/data outputs hold the m0 values (don't-care).

## Timing
- **Reset values.** All outputs are 0 during reset; `rd_pend`=0; `prio`=m0. Reset asserted mid-read drops the pending rvalid; no stale rvalid follows reset release.
- **Latency.**
  - Write: ack in cycle 0.
  - Read: ack in cycle 0, rvalid in cycle 1.
  - Error: ack and err in cycle 0.
- **Handshake.** A master holds `req` and all request fields stable until ack. The ack cycle transfers the request. `req` may drop or be re-asserted with a new request in the cycle after ack. A master that is not granted sees `ack`=0 and keeps waiting.
- **Back-pressure.** rvalid cannot be stalled; masters must accept read data on the cycle it is presented.
- **Fairness.** With both masters requesting continuously, grants alternate m0, m1, m0, …; there is no starvation.

## Structure
- Size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`) and the lane count belong in the shared `defines.v`.
- Sub-module `rr_arb2`: two-request round-robin arbiter holding the `prio` register; outputs a one-hot grant.
- Everything else (alignment check, lane steering, read-return register) lives in `ram_arb`.

## Test plan
- **Single write/read.** m0 writes word 0xDEADBEEF to 0x10, then reads 0x10 → `ram_wr_en_o`=1111 on the write; rvalid one cycle after the read ack with `rdata`=0xDEADBEEF.
- **Byte and half lanes.** m1 byte-writes 0xAB to 0x13 → `ram_wr_en_o`=1000, `ram_wr_data_o`=0xABABABAB. A subsequent byte read of 0x13 returns 0x000000AB; a half read of 0x12 returns 0x0000ABBE.
- **Contention.** Both masters request continuously for 6 cycles → acks go m0, m1, m0, m1, m0, m1; each read's rvalid goes to the correct master.
- **Misaligned access.** m0 word read at 0x02 → ack and err in the same cycle, no rvalid, `ram_wr_en_o`=0. A half write at 0x05 also raises err with no write.
- **Back-to-back pipelining.** m0 reads 0x0 and 0x4 in consecutive cycles → rvalid in two consecutive cycles with the correct data.
- **Reset mid-read.** Assert `rst_n` low in the cycle after a read ack → no rvalid; after release, `prio`=m0.
